pc_fetch_ctrl: RTL and testbench

//  Program-counter and fetch sequencer; consumer of the branch-target lookup table.

---
 rtl/pc_fetch_ctrl_pkg.sv | 6 +
 rtl/pc_fetch_ctrl_if.sv | 24 ++
 rtl/pc_fetch_ctrl_next.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 71 +++++++
 tb/tb_pc_fetch_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-side types: sequencer state encoding and PC/offset widths.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
  localparam int PC_W = 10;
  typedef logic signed [PC_W-1:0] pc_off_t;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Control/status bundle between the fetch sequencer and whoever drives it.
interface pc_fetch_ctrl_if #(parameter int D = 10, parameter int CNT_W = 16);
  logic             start;
  logic [D-1:0]     start_addr;
  logic             stall;
  logic             branch_taken;
  logic [D-1:0]     br_offset;
  logic             jump;
  logic [D-1:0]     jump_addr;
  logic             halt_req;
  logic [D-1:0]     pc;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, start_addr, stall, branch_taken, br_offset, jump, jump_addr, halt_req,
    input  pc, running, done, retired
  );
  modport slave (
    input  start, start_addr, stall, branch_taken, br_offset, jump, jump_addr, halt_req,
    output pc, running, done, retired
  );
endinterface

// File: rtl/pc_fetch_ctrl_next.sv
// Combinational next-PC select; all arithmetic wraps modulo 2^D.
module pc_next_calc #(parameter int D = 10) (
  input  logic               run,
  input  logic               start,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [D-1:0]       pc,
  input  logic [D-1:0]       start_addr,
  input  logic [D-1:0]       jump_addr,
  input  logic signed [D-1:0] br_offset,
  output logic [D-1:0]       pc_next
);
  always_comb begin
    pc_next = pc;
    if (start)
      pc_next = start_addr;
    else if (run) begin
      if (halt_req || stall) pc_next = pc;
      else if (jump)         pc_next = jump_addr;
      // Same-width add: the signed offset's two's-complement bits wrap naturally.
      else if (branch_taken) pc_next = pc + D'(br_offset);
      else                   pc_next = pc + D'(1);
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, IDLE/RUN/HALT sequencer and saturating retired-instruction counter.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int D     = PC_W,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_fetch_ctrl_if.slave  bus
);
  fetch_state_t     state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] retired_q;
  logic             clr, inc;

  pc_next_calc #(.D(D)) u_next (
    .run          (state_q == RUN),
    .start        (bus.start),
    .halt_req     (bus.halt_req),
    .stall        (bus.stall),
    .jump         (bus.jump),
    .branch_taken (bus.branch_taken),
    .pc           (pc_q),
    .start_addr   (bus.start_addr),
    .jump_addr    (bus.jump_addr),
    .br_offset    (bus.br_offset),
    .pc_next      (pc_d)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE, HALT: if (bus.start) begin
        state_d = RUN;
        clr     = 1'b1;
      end
      RUN: begin
        if (bus.start) clr = 1'b1;
        else if (bus.halt_req) begin
          state_d = HALT;
          inc     = 1'b1;
        end
        else if (!bus.stall) inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (clr)
        retired_q <= '0;
      else if (inc && (retired_q != '1))
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.pc      = pc_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == HALT);
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench: main instance (CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [27:0] exp_v;
  logic [15:0] exp_s;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.D(10), .CNT_W(16)) b ();
  pc_fetch_ctrl_if #(.D(10), .CNT_W(4))  s ();

  pc_fetch_ctrl #(.D(10), .CNT_W(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(b));
  pc_fetch_ctrl #(.D(10), .CNT_W(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(s));

  function automatic logic [27:0] obs();
    return {b.pc, b.running, b.done, b.retired};
  endfunction

  function automatic logic [15:0] obs4();
    return {s.pc, s.running, s.done, s.retired};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    b.start = 0; b.start_addr = 0; b.stall = 0; b.branch_taken = 0; b.br_offset = 0;
    b.jump = 0; b.jump_addr = 0; b.halt_req = 0;
    s.start = 0; s.start_addr = 0; s.stall = 0; s.branch_taken = 0; s.br_offset = 0;
    s.jump = 0; s.jump_addr = 0; s.halt_req = 0;
  endtask

  task automatic start_at(input logic [9:0] a);
    b.start = 1; b.start_addr = a; step(); b.start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0; #3;
    exp_v = {10'd0, 1'b0, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL reset_init got=%h exp=%h", obs(), exp_v); end
    @(posedge clk); #1; reset_n = 1;
    b.jump = 1; b.jump_addr = 10'd99; step(); b.jump = 0;
    exp_v = {10'd0, 1'b0, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL idle_ignores_jump got=%h exp=%h", obs(), exp_v); end
    start_at(10'd30);
    repeat (7) step();
    exp_v = {10'd37, 1'b1, 1'b0, 16'd7}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL pre_reset_run got=%h exp=%h", obs(), exp_v); end
    #2 reset_n = 0; #1;
    exp_v = {10'd0, 1'b0, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", obs(), exp_v); end
    step(); reset_n = 1; step();
  endtask

  task automatic test_sequential();
    start_at(10'd100);
    exp_v = {10'd100, 1'b1, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL seq_start got=%h exp=%h", obs(), exp_v); end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_v = {10'(100 + i), 1'b1, 1'b0, 16'(i)}; n_chk++;
      if (obs() !== exp_v) begin n_fail++; $display("FAIL seq_step%0d got=%h exp=%h", i, obs(), exp_v); end
    end
  endtask

  task automatic test_branch();
    start_at(10'd50);
    b.branch_taken = 1; b.br_offset = -10'sd5; step();
    exp_v = {10'd45, 1'b1, 1'b0, 16'd1}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL br_minus5 got=%h exp=%h", obs(), exp_v); end
    b.br_offset = 10'd20; step();
    exp_v = {10'd65, 1'b1, 1'b0, 16'd2}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL br_plus20 got=%h exp=%h", obs(), exp_v); end
    b.br_offset = 10'd0; step();
    exp_v = {10'd65, 1'b1, 1'b0, 16'd3}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL br_selfloop got=%h exp=%h", obs(), exp_v); end
    b.branch_taken = 0;
    start_at(10'd0);
    b.branch_taken = 1; b.br_offset = -10'sd1; step(); b.branch_taken = 0;
    exp_v = {10'd1023, 1'b1, 1'b0, 16'd1}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL br_wrap_neg got=%h exp=%h", obs(), exp_v); end
    step();
    exp_v = {10'd0, 1'b1, 1'b0, 16'd2}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL inc_wrap got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_stall_jump();
    start_at(10'd10);
    b.stall = 1; b.jump = 1; b.jump_addr = 10'd300;
    repeat (3) step();
    b.stall = 0;
    exp_v = {10'd10, 1'b1, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", obs(), exp_v); end
    b.jump_addr = 10'd200; b.branch_taken = 1; b.br_offset = 10'd5; step();
    b.jump = 0; b.branch_taken = 0;
    exp_v = {10'd200, 1'b1, 1'b0, 16'd1}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL jump_over_branch got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_halt();
    start_at(10'd5);
    repeat (2) step();
    b.halt_req = 1; b.stall = 1; step(); b.halt_req = 0; b.stall = 0;
    exp_v = {10'd7, 1'b0, 1'b1, 16'd3}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL halt_enter got=%h exp=%h", obs(), exp_v); end
    b.branch_taken = 1; b.br_offset = 10'd3; b.jump = 1; b.jump_addr = 10'd99; b.halt_req = 1;
    repeat (3) step();
    b.branch_taken = 0; b.jump = 0; b.halt_req = 0;
    exp_v = {10'd7, 1'b0, 1'b1, 16'd3}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL halt_frozen got=%h exp=%h", obs(), exp_v); end
    start_at(10'd0);
    exp_v = {10'd0, 1'b1, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL halt_restart got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_back_to_back();
    start_at(10'd400);
    step(); step();
    b.start = 1; b.start_addr = 10'd600; b.halt_req = 1; b.jump = 1; step();
    b.start = 0; b.halt_req = 0; b.jump = 0;
    exp_v = {10'd600, 1'b1, 1'b0, 16'd0}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL restart_priority got=%h exp=%h", obs(), exp_v); end
    step();
    exp_v = {10'd601, 1'b1, 1'b0, 16'd1}; n_chk++;
    if (obs() !== exp_v) begin n_fail++; $display("FAIL restart_follow got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_saturate();
    s.start = 1; s.start_addr = 10'd0; step(); s.start = 0;
    repeat (15) step();
    exp_s = {10'd15, 1'b1, 1'b0, 4'd15}; n_chk++;
    if (obs4() !== exp_s) begin n_fail++; $display("FAIL sat_reach got=%h exp=%h", obs4(), exp_s); end
    repeat (5) step();
    exp_s = {10'd20, 1'b1, 1'b0, 4'd15}; n_chk++;
    if (obs4() !== exp_s) begin n_fail++; $display("FAIL sat_stick got=%h exp=%h", obs4(), exp_s); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_jump();
    test_halt();
    test_back_to_back();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
